// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO feeding a start/data/stop serialiser.
// Define UART_TX_RUNNING_STATUS_EN to drop repeated MIDI channel-status bytes at the pop.
module uart_tx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BAUD_DIV   = 1,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic                        tx,
  output logic                        busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned IdxW = 4;

  localparam logic [CntW-1:0] CntLast  = CntW'(BAUD_DIV - 1);
  localparam logic [IdxW-1:0] DataLast = IdxW'(DATA_W - 1);
  localparam logic [IdxW-1:0] StopLast = IdxW'(STOP_BITS - 1);
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StData  = 2'd2;
  localparam logic [1:0] StStop  = 2'd3;

  // Elaboration-time parameter checks.
  if (DATA_W < 5 || DATA_W > 9) begin : gen_bad_data_w
    $error("uart_tx_fifo: DATA_W must be in 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (BAUD_DIV < 1) begin : gen_bad_baud
    $error("uart_tx_fifo: BAUD_DIV must be >= 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
`ifdef UART_TX_RUNNING_STATUS_EN
  if (DATA_W != 8) begin : gen_bad_rs_width
    $error("uart_tx_fifo: running status requires DATA_W == 8");
  end
`endif

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;

  assign full     = (level_q == LvlFull);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = overflow_q;
  assign head     = mem_q[rd_ptr_q];

  // full comes from registered level, so a pop in the same cycle never frees a slot early.
  assign push = wr_en && !full;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = wr_en && full;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Head classification
  // ---------------------------------------------------------------------------
  logic send_head;

`ifdef UART_TX_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;
  logic [7:0] head_byte;
  logic       is_chan;
  logic       is_sys_common;

  assign head_byte     = head[7:0];
  assign is_chan       = head_byte[7] && (head_byte[7:4] != 4'hF);
  assign is_sys_common = (head_byte[7:3] == 5'b11110);
  assign send_head     = !(is_chan && (head_byte == last_status_q));

  always_comb begin
    last_status_d = last_status_q;
    if (pop) begin
      if (is_chan) begin
        last_status_d = head_byte;
      end else if (is_sys_common) begin
        last_status_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_status_q <= 8'h00;
    end else begin
      last_status_q <= last_status_d;
    end
  end
`else
  assign send_head = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_last;
  logic              frame_slot;

  assign bit_last = (bit_cnt_q == CntLast);
  // A new frame may start from idle or on the final pulse of the last stop bit.
  assign frame_slot = clk_en && ((state_q == StIdle) ||
                      ((state_q == StStop) && bit_last && (idx_q == StopLast)));
  assign pop  = frame_slot && !empty;
  assign tx   = tx_q;
  assign busy = (state_q != StIdle) || !empty;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    if (frame_slot) begin
      bit_cnt_d = '0;
      idx_d     = '0;
      if (pop && send_head) begin
        shift_d = head;
        tx_d    = 1'b0;
        state_d = StStart;
      end else begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    end else if (clk_en) begin
      unique case (state_q)
        StStart: begin
          if (bit_last) begin
            bit_cnt_d = '0;
            idx_d     = '0;
            tx_d      = shift_q[0];
            state_d   = StData;
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_last) begin
            bit_cnt_d = '0;
            if (idx_q == DataLast) begin
              idx_d   = '0;
              tx_d    = 1'b1;
              state_d = StStop;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              shift_d = shift_q >> 1;
              tx_d    = shift_q[1];
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (bit_last) begin
            bit_cnt_d = '0;
            idx_d     = idx_q + IdxW'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: decodes the serial line into frames and
// compares them with a byte-level reference model.
module tb_uart_tx_fifo;

`ifdef UART_TX_RUNNING_STATUS_EN
  localparam bit RsEn = 1'b1;
`else
  localparam bit RsEn = 1'b0;
`endif
  localparam int unsigned Dw2 = RsEn ? 8 : 7;
  localparam int unsigned Bd2 = 4;
  localparam int unsigned Sb2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, overflow, tx, busy;
  logic [4:0] level;

  logic           clk_en2 = 1'b0;
  logic           wr_en2 = 1'b0;
  logic [Dw2-1:0] wr_data2 = '0;
  logic           full2, empty2, overflow2, tx2, busy2;
  logic [2:0]     level2;

  int checks = 0;
  int errors = 0;

  bit         log1[$];
  bit         log2[$];
  int         frames[$];
  logic [7:0] expq[$];
  logic [7:0] rs_last = 8'h00;
  logic       en_s, en2_s;

  uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(16), .BAUD_DIV(1), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .tx(tx), .busy(busy)
  );

  uart_tx_fifo #(.DATA_W(Dw2), .FIFO_DEPTH(4), .BAUD_DIV(Bd2), .STOP_BITS(Sb2)) dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en2), .wr_en(wr_en2), .wr_data(wr_data2),
    .full(full2), .empty(empty2), .level(level2), .overflow(overflow2), .tx(tx2),
    .busy(busy2)
  );

  always #5 clk = ~clk;

  // One log entry per clk_en pulse: the line level for the following period.
  always @(posedge clk) begin
    en_s  = clk_en;
    en2_s = clk_en2;
    #1;
    if (en_s) log1.push_back(tx);
    if (en2_s) log2.push_back(tx2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Byte-level model: returns whether a popped byte should appear on the line.
  function automatic bit model_keep(input logic [7:0] b);
    if (RsEn && b >= 8'h80 && b <= 8'hEF) begin
      if (b == rs_last) return 1'b0;
      rs_last = b;
    end else if (RsEn && b >= 8'hF0 && b <= 8'hF7) begin
      rs_last = 8'h00;
    end
    return 1'b1;
  endfunction

  // Turns a per-period line log into frame values; counts malformed periods in bad.
  task automatic decode(input int sel, input int div, input int dw, input int stops,
                        output int bad);
    bit lg[$];
    int i, flen, v;
    bit b;
    frames.delete();
    bad = 0;
    if (sel == 0) lg = log1;
    else lg = log2;
    i = 0;
    flen = div * (1 + dw + stops);
    while (i < lg.size()) begin
      if (lg[i]) begin
        i++;
      end else if (i + flen > lg.size()) begin
        bad++;
        i = lg.size();
      end else begin
        v = 0;
        for (int s = 0; s < 1 + dw + stops; s++) begin
          b = lg[i + s * div];
          for (int j = 1; j < div; j++) if (lg[i + s * div + j] != b) bad++;
          if (s == 0) begin
            if (b) bad++;
          end else if (s > dw) begin
            if (!b) bad++;
          end else begin
            v |= int'(b) << (s - 1);
          end
        end
        frames.push_back(v);
        i += flen;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_en = 1'b0;
    clk_en2 = 1'b0;
    wr_en = 1'b0;
    wr_en2 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rs_last = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx_held: got %b want 1", tx); end
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", empty); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    checks++; if (tx2 !== 1'b1) begin errors++; $display("FAIL rst_tx2: got %b want 1", tx2); end
    checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy2: got %b want 0", busy2); end
  endtask

  task automatic test_single();
    logic [9:0] want, got;
    want = {1'b1, 8'h80, 1'b0};
    void'(model_keep(8'h80));
    clk_en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h80;
    @(negedge clk);
    wr_en = 1'b0;
    log1.delete();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_wr: got %b want 1", busy); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_lvl: got %0d want 1", level); end
    @(negedge clk);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_pop: got %b want 1", empty); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL single_start: got %b want 0", tx); end
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    got = '1;
    for (int i = 0; i < 10 && i < log1.size(); i++) got[i] = log1[i];
    checks++;
    if (log1.size() < 10 || got !== want) begin
      errors++; $display("FAIL single_bits: got %b want %b (lsb first)", got, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] want, got;
    want = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    void'(model_keep(8'h55));
    void'(model_keep(8'hAA));
    clk_en = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL b2b_lvl2: got %0d want 2", level); end
    log1.delete();
    clk_en = 1'b1;
    @(negedge clk);
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL b2b_lvl1: got %0d want 1", level); end
    repeat (10) @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL b2b_lvl0: got %0d want 0", level); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start2: got %b want 0", tx); end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
    got = '1;
    for (int i = 0; i < 20 && i < log1.size(); i++) got[i] = log1[i];
    checks++;
    if (log1.size() < 20 || got !== want) begin
      errors++; $display("FAIL b2b_bits: got %b want %b (lsb first)", got, want);
    end
  endtask

  task automatic test_overflow();
    int n, bad;
    clk_en = 1'b0;
    log1.delete();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i);
      @(negedge clk);
      if (i == 15) begin
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", full); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b want 1", overflow); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_lvl: got %0d want 16", level); end
    wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_once: got %b want 0", overflow); end
    clk_en = 1'b1;
    n = 0;
    while (busy && n < 1000) begin @(negedge clk); n++; end
    checks++; if (busy) begin errors++; $display("FAIL ovf_drain: got busy want idle"); end
    decode(0, 1, 8, 1, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL ovf_framing: got %0d bad want 0", bad); end
    checks++;
    if (frames.size() != 16) begin
      errors++; $display("FAIL ovf_count: got %0d frames want 16", frames.size());
    end
    for (int i = 0; i < frames.size() && i < 16; i++) begin
      checks++;
      if (frames[i] != i) begin errors++; $display("FAIL ovf_data: got %0h want %0h", frames[i], i); end
    end
  endtask

  task automatic test_timing();
    int total, bad, lead;
    total = Bd2 * (1 + Dw2 + Sb2);
    wr_en2 = 1'b1;
    wr_data2 = Dw2'(8'h41);
    @(negedge clk);
    wr_en2 = 1'b0;
    log2.delete();
    for (int p = 0; p <= total; p++) begin
      clk_en2 = 1'b1;
      @(negedge clk);
      clk_en2 = 1'b0;
      if (p == total - 1) begin
        checks++;
        if (busy2 !== 1'b1) begin errors++; $display("FAIL tim_busy_last: got %b want 1", busy2); end
      end
      if (p == total) begin
        checks++;
        if (busy2 !== 1'b0) begin errors++; $display("FAIL tim_busy_end: got %b want 0", busy2); end
      end
      @(negedge clk);
      @(negedge clk);
    end
    lead = 0;
    while (lead < log2.size() && !log2[lead]) lead++;
    checks++; if (lead != Bd2) begin errors++; $display("FAIL tim_start: got %0d want %0d", lead, Bd2); end
    decode(1, Bd2, Dw2, Sb2, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL tim_framing: got %0d bad want 0", bad); end
    checks++;
    if (frames.size() != 1 || frames[0] != 'h41) begin
      errors++; $display("FAIL tim_frame: got %0d frames want 1 frame of 41", frames.size());
    end
  endtask

  task automatic test_random();
    int m, gap, n, bad;
    logic [7:0] b;
    do_reset();
    expq.delete();
    log1.delete();
    for (int round = 0; round < 3; round++) begin
      m = $urandom_range(1, 16);
      for (int k = 0; k < m; k++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          clk_en = (round != 0) && ($urandom_range(0, 1) == 1);
          @(negedge clk);
        end
        b = ($urandom_range(0, 3) == 0) ? 8'h90 : 8'($urandom_range(0, 255));
        wr_en = 1'b1;
        wr_data = b;
        clk_en = (round != 0) && ($urandom_range(0, 1) == 1);
        @(negedge clk);
        wr_en = 1'b0;
        if (model_keep(b)) expq.push_back(b);
      end
      if (round == 0) begin
        checks++;
        if (level !== 5'(m)) begin errors++; $display("FAIL rnd_lvl: got %0d want %0d", level, m); end
        checks++;
        if (full !== (m == 16)) begin errors++; $display("FAIL rnd_full: got %b want %b", full, m == 16); end
      end
      n = 0;
      while (busy && n < 3000) begin
        clk_en = ($urandom_range(0, 1) == 1);
        @(negedge clk);
        n++;
      end
      checks++; if (busy) begin errors++; $display("FAIL rnd_drain: got busy want idle"); end
    end
    clk_en = 1'b0;
    decode(0, 1, 8, 1, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_framing: got %0d bad want 0", bad); end
    checks++;
    if (frames.size() != expq.size()) begin
      errors++; $display("FAIL rnd_count: got %0d want %0d", frames.size(), expq.size());
    end
    for (int i = 0; i < frames.size() && i < expq.size(); i++) begin
      checks++;
      if (frames[i] != int'(expq[i])) begin
        errors++; $display("FAIL rnd_data[%0d]: got %0h want %0h", i, frames[i], expq[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int zeros;
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i * 'h11);
      @(negedge clk);
    end
    wr_en = 1'b0;
    clk_en = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b want 0", tx); end
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL mid_lvl3: got %0d want 3", level); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_tx: got %b want 1", tx); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_lvl: got %0d want 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    rs_last = 8'h00;
    log1.delete();
    repeat (30) @(negedge clk);
    zeros = 0;
    foreach (log1[i]) if (!log1[i]) zeros++;
    checks++; if (zeros != 0) begin errors++; $display("FAIL mid_resume: got %0d low bits want 0", zeros); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: got %b want 0", busy); end
    clk_en = 1'b0;
  endtask

`ifdef UART_TX_RUNNING_STATUS_EN
  task automatic test_running_status();
    logic [7:0] seq[$];
    int want[$];
    int n, bad;
    for (int v = 0; v < 3; v++) begin
      do_reset();
      log1.delete();
      seq = '{8'h90, 8'h3C, 8'h40};
      if (v == 1) seq.push_back(8'hF8);
      if (v == 2) seq.push_back(8'hF0);
      seq.push_back(8'h90);
      seq.push_back(8'h3E);
      seq.push_back(8'h40);
      if (v == 0) want = '{'h90, 'h3C, 'h40, 'h3E, 'h40};
      if (v == 1) want = '{'h90, 'h3C, 'h40, 'hF8, 'h3E, 'h40};
      if (v == 2) want = '{'h90, 'h3C, 'h40, 'hF0, 'h90, 'h3E, 'h40};
      foreach (seq[i]) begin
        wr_en = 1'b1;
        wr_data = seq[i];
        @(negedge clk);
      end
      wr_en = 1'b0;
      clk_en = 1'b1;
      n = 0;
      while (busy && n < 1000) begin @(negedge clk); n++; end
      clk_en = 1'b0;
      checks++; if (busy) begin errors++; $display("FAIL rs_drain: got busy want idle"); end
      decode(0, 1, 8, 1, bad);
      checks++; if (bad != 0) begin errors++; $display("FAIL rs_framing: got %0d bad want 0", bad); end
      checks++;
      if (frames.size() != want.size()) begin
        errors++; $display("FAIL rs_count v%0d: got %0d want %0d", v, frames.size(), want.size());
      end
      for (int i = 0; i < frames.size() && i < want.size(); i++) begin
        checks++;
        if (frames[i] != want[i]) begin
          errors++; $display("FAIL rs_data v%0d[%0d]: got %0h want %0h", v, i, frames[i], want[i]);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_timing();
    test_random();
    test_reset_mid();
`ifdef UART_TX_RUNNING_STATUS_EN
    test_running_status();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
